// File: rtl/vex_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : vex_pkg                                                     |
// | Shared opcodes, sequencer state encoding and LMUL legality helper.    |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
package vex_pkg;

    localparam logic [6:0] OP_VLOAD  = 7'h07;
    localparam logic [6:0] OP_VSTORE = 7'h27;
    localparam logic [6:0] OP_VARITH = 7'h57;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ALU  = 3'd1,
        ST_MEM  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Group size n = lmul+1 must be a power of two no larger than max_lmul.
    function automatic logic lmul_legal(input logic [2:0] lmul, input int max_lmul);
        logic pow2;
        pow2 = (lmul == 3'd0) || (lmul == 3'd1) || (lmul == 3'd3) || (lmul == 3'd7);
        return pow2 && ((int'(lmul) + 1) <= max_lmul);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vex_wb_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : vex_wb_pipe                                                  |
// | Valid + write-address delay line matching the VALU pipeline depth.    |
// | Depth 0 is a combinational pass-through.                              |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module vex_wb_pipe #(
    parameter int ALU_LAT = 2,
    parameter int RW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [RW-1:0] in_addr,
    output logic          out_valid,
    output logic [RW-1:0] out_addr
);

    generate
        if (ALU_LAT == 0) begin : g_pass
            assign out_valid = in_valid;
            assign out_addr  = in_addr;
        end else begin : g_delay
            logic [ALU_LAT-1:0] valid_sr;
            logic [RW-1:0]      addr_sr [ALU_LAT];

            // Shift valid and address together; reset empties the line.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_sr <= '0;
                    for (int i = 0; i < ALU_LAT; i++) addr_sr[i] <= '0;
                end else begin
                    valid_sr[0] <= in_valid;
                    addr_sr[0]  <= in_addr;
                    for (int i = 1; i < ALU_LAT; i++) begin
                        valid_sr[i] <= valid_sr[i-1];
                        addr_sr[i]  <= addr_sr[i-1];
                    end
                end
            end

            assign out_valid = valid_sr[ALU_LAT-1];
            assign out_addr  = addr_sr[ALU_LAT-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vex_group_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : vex_group_sequencer                                          |
// | Vector-execute sequencer: walks an LMUL register group through the    |
// | VRF/VALU, dispatches loads/stores to the VMA, rejects illegal groups. |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module vex_group_sequencer
    import vex_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int ALU_LAT  = 2,
    parameter int MAX_LMUL = 8,
    localparam int RW      = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [6:0]    i_ops,
    input  logic [5:0]    i_funct6,
    input  logic [2:0]    i_funct3,
    input  logic [RW-1:0] i_vs1a,
    input  logic [RW-1:0] i_vs2a,
    input  logic [RW-1:0] i_vda,
    input  logic [2:0]    i_lmul,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_illegal,
    output logic          o_rd_en,
    output logic [RW-1:0] o_vs1a,
    output logic [RW-1:0] o_vs2a,
    output logic [5:0]    o_alu_ctrl,
    output logic          o_we,
    output logic [RW-1:0] o_wad,
    output logic          o_mem_start,
    output logic [1:0]    o_mem_mop,
    output logic [2:0]    o_mem_width,
    input  logic          i_mem_done
);

    // Step counter spans n reads plus ALU_LAT drain cycles (max 7+4).
    localparam logic [3:0] LAT4 = 4'(ALU_LAT);

    state_t        state;
    state_t        state_nx;
    logic [3:0]    step;
    logic [RW-1:0] vs1_q;
    logic [RW-1:0] vs2_q;
    logic [RW-1:0] vd_q;
    logic [2:0]    lmul_q;
    logic [5:0]    funct6_q;
    logic [2:0]    funct3_q;

    logic          accept;
    logic          group_ok;
    logic          aligned;
    logic          rd_en;
    logic          wb_valid;
    logic [RW-1:0] wb_addr;

    assign accept   = i_valid && (state == ST_IDLE);
    assign group_ok = lmul_legal(i_lmul, MAX_LMUL);
    // For a power-of-two group, alignment means the low lmul bits are all zero.
    assign aligned  = ((i_vs1a | i_vs2a | i_vda) & RW'(i_lmul)) == '0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nx    = state;
        o_ready     = 1'b0;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        o_illegal   = 1'b0;
        o_mem_start = 1'b0;
        rd_en       = 1'b0;
        case (state)
            ST_IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                if (i_valid) begin
                    if (i_ops == OP_VARITH && group_ok && aligned)
                        state_nx = ST_ALU;
                    else if ((i_ops == OP_VLOAD || i_ops == OP_VSTORE) && group_ok)
                        state_nx = ST_MEM;
                    else
                        state_nx = ST_ERR;
                end
            end
            ST_ALU: begin
                rd_en = (step <= {1'b0, lmul_q});
                if (step == {1'b0, lmul_q} + LAT4) state_nx = ST_DONE;
            end
            ST_MEM: begin
                o_mem_start = (step == 4'd0);
                if (i_mem_done) state_nx = ST_DONE;
            end
            ST_DONE: begin
                o_done   = 1'b1;
                state_nx = ST_IDLE;
            end
            ST_ERR: begin
                o_illegal = 1'b1;
                state_nx  = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Step counter: restarts on accept, counts ALU steps, marks MEM start issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            step <= '0;
        else if (accept)
            step <= '0;
        else if (state == ST_ALU)
            step <= step + 4'd1;
        else if (state == ST_MEM && step == 4'd0)
            step <= 4'd1;
    end

    // Latch instruction fields at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs1_q    <= '0;
            vs2_q    <= '0;
            vd_q     <= '0;
            lmul_q   <= '0;
            funct6_q <= '0;
            funct3_q <= '0;
        end else if (accept) begin
            vs1_q    <= i_vs1a;
            vs2_q    <= i_vs2a;
            vd_q     <= i_vda;
            lmul_q   <= i_lmul;
            funct6_q <= i_funct6;
            funct3_q <= i_funct3;
        end
    end

    vex_wb_pipe #(
        .ALU_LAT (ALU_LAT),
        .RW      (RW)
    ) u_wb_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_en),
        .in_addr   (vd_q + RW'(step)),
        .out_valid (wb_valid),
        .out_addr  (wb_addr)
    );

    assign o_rd_en     = rd_en;
    assign o_vs1a      = rd_en ? vs1_q + RW'(step) : '0;
    assign o_vs2a      = rd_en ? vs2_q + RW'(step) : '0;
    assign o_alu_ctrl  = funct6_q;
    assign o_we        = wb_valid;
    assign o_wad       = wb_valid ? wb_addr : '0;
    assign o_mem_mop   = funct6_q[1:0];
    assign o_mem_width = funct3_q;

endmodule
`default_nettype wire
